// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer for a bus-based CPU datapath (fetch, decode, execute).
// Optional macro CTRL_MULDIV_EN enables the mul/div sequence through T6; otherwise those opcodes are illegal.
module control_sequencer (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        mem_done,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        Cout,
  output logic [4:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T1W = 4'd3, S_T2 = 4'd4,
    S_T3 = 4'd5, S_T4 = 4'd6, S_T5 = 4'd7, S_T6 = 4'd8, S_HALT = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE = 3'd0, C_IMM = 3'd1, C_MULDIV = 3'd2, C_NOP = 3'd3, C_HALT = 3'd4, C_UNDEF = 3'd5
  } op_class_t;

  state_t      state_r;
  op_class_t   cls_s;
  logic [4:0]  op_s;
  logic        unused_s;

  function automatic op_class_t classify(input logic [4:0] op);
    case (op)
      5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b00111, 5'b01000: classify = C_RTYPE;
      5'b01001, 5'b01010, 5'b01011:           classify = C_IMM;
`ifdef CTRL_MULDIV_EN
      5'b01111, 5'b10000:                     classify = C_MULDIV;
`endif
      5'b11010:                               classify = C_NOP;
      5'b11011:                               classify = C_HALT;
      default:                                classify = C_UNDEF;
    endcase
  endfunction

  // Immediate forms reuse the ALU codes of their register counterparts.
  function automatic logic [4:0] imm_alu(input logic [4:0] op);
    case (op)
      5'b01001: imm_alu = 5'b00000;
      5'b01010: imm_alu = 5'b00010;
      5'b01011: imm_alu = 5'b00011;
      default:  imm_alu = 5'b00000;
    endcase
  endfunction

  assign op_s     = IR[31:27];
  assign cls_s    = classify(op_s);
  assign unused_s = ^IR[26:0];

  // State register: clear dominates every state, mem_done only matters in the fetch wait.
  always_ff @(posedge clock) begin
    if (!clear) begin
      state_r <= S_IDLE;
    end else begin
      case (state_r)
        S_IDLE: state_r <= S_T0;
        S_T0:   state_r <= S_T1;
        S_T1:   state_r <= mem_done ? S_T2 : S_T1W;
        S_T1W:  state_r <= mem_done ? S_T2 : S_T1W;
        S_T2:   state_r <= S_T3;
        S_T3: begin
          case (cls_s)
            C_RTYPE, C_IMM, C_MULDIV: state_r <= S_T4;
            C_HALT:                   state_r <= S_HALT;
            default:                  state_r <= S_T0;
          endcase
        end
        S_T4:   state_r <= S_T5;
        S_T5:   state_r <= (cls_s == C_MULDIV) ? S_T6 : S_T0;
        S_T6:   state_r <= S_T0;
        S_HALT: state_r <= S_HALT;
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Output decode from the current state and IR; IR is reloaded at the end of T2,
  // so the strobes must follow the live IR rather than a copy taken a cycle early.
  always_comb begin
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
    MARin = 1'b0; Zin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
    Yin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; Cout = 1'b0;
    alu_op = 5'b00000; run = 1'b1; illegal_op = 1'b0;
    case (state_r)
      S_IDLE: begin end
      S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_T1W: begin Read = 1'b1; MDRin = 1'b1; end
      S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls_s)
          C_RTYPE, C_IMM: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_MULDIV:       begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          C_UNDEF:        illegal_op = 1'b1;
          default:        begin end
        endcase
      end
      S_T4: begin
        case (cls_s)
          C_RTYPE:  begin Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_s; end
          C_IMM:    begin Cout = 1'b1; Zin = 1'b1; alu_op = imm_alu(op_s); end
          C_MULDIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; alu_op = op_s; end
          default:  begin end
        endcase
      end
      S_T5: begin
        case (cls_s)
          C_RTYPE, C_IMM: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          C_MULDIV:       begin Zlowout = 1'b1; LOin = 1'b1; end
          default:        begin end
        endcase
      end
      S_T6: begin Zhighout = 1'b1; HIin = 1'b1; end
      S_HALT: run = 1'b0;
      default: begin end
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clock  input  1  sole clock; all state changes on rising edge.
REQ-002 clear  input  1  reset, synchronous, active-low; sampled on rising edge of clock.
REQ-003 IR  input  32  instruction register contents; [31:27] op, [26:23] ra, [22:19] rb, [18:15] rc, [18:0] C.
REQ-004 mem_done  input  1  memory read complete; high in cycle data is valid on Mdatain.
REQ-005 PCout, Zlowout, Zhighout, MDRout  output  1 each  bus-drive strobes to datapath.
REQ-006 MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  output  1 each  register load strobes.
REQ-007 IncPC, Read  output  1 each  ALU PC-increment select; memory read request.
REQ-008 Gra, Grb, Grc, Rin, Rout, Cout  output  1 each  select-and-encode controls; Cout drives sign-extended C onto bus.
REQ-009 alu_op  output  5  ALU operation code.
REQ-010 run  output  1  high while executing; low once halted.
REQ-011 illegal_op  output  1  one-cycle pulse on undefined opcode.

Function
REQ-012 Opcodes: 00000 add, 00001 sub, 00010 and, 00011 or, 00100 shr, 00101 shra, 00110 shl, 00111 ror, 01000 rol (R-type); 01001 addi, 01010 andi, 01011 ori (imm); 01111 mul, 10000 div; 11010 nop; 11011 halt; all others undefined.
REQ-013 States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT; all outputs decoded from current state and IR only (Moore), stable for whole cycle.
REQ-014 Strobes not listed for a state are 0; alu_op is 00000 outside T4.
REQ-015 IDLE: all outputs 0, run=1; next T0.
REQ-016 T0: PCout, MARin, IncPC, Zin; next T1.
REQ-017 T1: Zlowout, PCin, Read, MDRin; next T2 if mem_done=1, else T1W.
REQ-018 T1W: Read, MDRin only (no PCin); stay while mem_done=0; next T2 when mem_done=1.
REQ-019 T2: MDRout, IRin; next T3.
REQ-020 R-type/imm T3: Grb, Rout, Yin. R-type T4: Grc, Rout, Zin, alu_op=IR[31:27]. Imm T4: Cout, Zin, alu_op = add/and/or code for addi/andi/ori. T5: Zlowout, Gra, Rin; next T0.
REQ-021 mul/div: T3 Gra, Rout, Yin; T4 Grb, Rout, Zin, alu_op=IR[31:27]; T5 Zlowout, LOin; T6 Zhighout, HIin; next T0.
REQ-022 nop: T3 asserts nothing; next T0.
REQ-023 halt: T3 asserts nothing; next HALT. HALT: all strobes 0, run=0; stays until clear.
REQ-024 Undefined opcode: T3 asserts illegal_op only; next T0 (treated as nop).
REQ-025 Instruction latency: R-type/imm 6 cycles, mul/div 7, nop/undefined 4, each plus one per T1W cycle.
REQ-026 mem_done is ignored in every state other than T1/T1W.

Reset
REQ-027 clear=0 at a rising edge forces state IDLE from any state, including mid-instruction, T1W and HALT; in-flight strobes drop next cycle.
REQ-028 While clear held low, state remains IDLE: all strobes 0, alu_op=00000, illegal_op=0, run=1.

Configuration
REQ-029 Macro CTRL_MULDIV_EN: defined -> mul/div per REQ-021; undefined -> opcodes 01111/10000 treated as undefined per REQ-024, T6 unreachable.

Verification
REQ-030 Reset: clear low 2 cycles then high -> IDLE with all outputs 0, run=1; T0 next cycle with PCout=MARin=IncPC=Zin=1.
REQ-031 IR=0x1091_8000 (and R1,R2,R3), mem_done tied 1 -> T3 Grb/Rout/Yin, T4 Grc/Rout/Zin/alu_op=00010, T5 Zlowout/Gra/Rin, T0 at cycle 7.
REQ-032 mem_done low 3 cycles after T1 -> exactly one PCin cycle, Read/MDRin high 4 cycles, IRin in cycle after mem_done=1.
REQ-033 IR op=01001 (addi) -> T4 Cout=1, alu_op=00000; IR op=11011 -> HALT, run=0 persisting 20 cycles with mem_done toggling.
REQ-034 IR op=01111 with CTRL_MULDIV_EN -> T5 LOin, T6 HIin; without -> illegal_op pulse in T3, T0 next.
REQ-035 clear low during T4 -> IDLE next edge, Zin=0, then normal fetch from T0.
